muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_sign_cond.sv | 26 ++
 rtl/muldiv_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam int DATA_W  = 32;
   localparam int DWORD_W = 64;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef logic [1:0] md_state_t;

   localparam md_state_t ST_IDLE     = 2'd0;
   localparam md_state_t ST_MUL_BUSY = 2'd1;
   localparam md_state_t ST_DIV_BUSY = 2'd2;
   localparam md_state_t ST_DONE     = 2'd3;

endpackage

// File: rtl/muldiv_sign_cond.sv
// Operand magnitude and result-sign logic; inv_a_i forces a two's-complement
// negate of operand A so the same block can flip a 64-bit product.
module muldiv_sign_cond
   import muldiv_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         signed_i,
   input  logic         inv_a_i,
   output logic [W-1:0] mag_a_o,
   output logic [W-1:0] mag_b_o,
   output logic         neg_o
);

   logic neg_a;
   logic neg_b;

   assign neg_a   = inv_a_i | (signed_i & a_i[W-1]);
   assign neg_b   = signed_i & b_i[W-1];
   assign mag_a_o = neg_a ? -a_i : a_i;
   assign mag_b_o = neg_b ? -b_i : b_i;
   assign neg_o   = signed_i & (a_i[W-1] ^ b_i[W-1]);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle HI/LO units: launches the pipelined multiplier
// or the iterative divider, stalls EX until a result exists, then holds the write.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT     = 3,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_valid_i,
   input  logic [1:0]   req_op_i,
   input  logic [31:0]  opa_i,
   input  logic [31:0]  opb_i,
   input  logic         ex_stall_i,
   input  logic         flush_i,
   output logic [31:0]  mul_a_o,
   output logic [31:0]  mul_b_o,
   input  logic [63:0]  mul_prod_i,
   output logic         div_start_o,
   output logic         div_signed_o,
   output logic         div_annul_o,
   output logic [31:0]  div_a_o,
   output logic [31:0]  div_b_o,
   input  logic         div_ready_i,
   input  logic [63:0]  div_result_i,
   output logic         stall_req_o,
   output logic         hilo_we_o,
   output logic [31:0]  hi_o,
   output logic [31:0]  lo_o,
   output logic         err_o
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT + MUL_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

   md_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [DATA_W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [DATA_W-1:0]  div_a_q, div_a_d, div_b_q, div_b_d;
   logic               div_signed_q, div_signed_d;
   logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic               we_q, we_d;
   logic               err_q, err_d;
   logic               annul;

   logic [DATA_W-1:0]  op_mag_a, op_mag_b;
   logic               op_neg;
   logic [DWORD_W-1:0] res_prod;
   logic [DWORD_W-1:0] unused_res_b;
   logic               unused_res_neg;

   muldiv_sign_cond #(.W(DATA_W)) u_op_cond (
      .a_i      (opa_i),
      .b_i      (opb_i),
      .signed_i (req_op_i == MD_MULT),
      .inv_a_i  (1'b0),
      .mag_a_o  (op_mag_a),
      .mag_b_o  (op_mag_b),
      .neg_o    (op_neg)
   );

   // The multiplier only sees magnitudes, so a signed product is fixed up here.
   muldiv_sign_cond #(.W(DWORD_W)) u_res_cond (
      .a_i      (mul_prod_i),
      .b_i      ('0),
      .signed_i (1'b0),
      .inv_a_i  (neg_q),
      .mag_a_o  (res_prod),
      .mag_b_o  (unused_res_b),
      .neg_o    (unused_res_neg)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      neg_d        = neg_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      div_a_d      = div_a_q;
      div_b_d      = div_b_q;
      div_signed_d = div_signed_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      we_d         = we_q;
      err_d        = err_q;
      annul        = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
         we_d    = 1'b0;
         cnt_d   = '0;
         annul   = (state_q == ST_DIV_BUSY);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  cnt_d = '0;
                  if (!req_op_i[1]) begin
                     neg_d   = op_neg;
                     mul_a_d = op_mag_a;
                     mul_b_d = op_mag_b;
                     state_d = ST_MUL_BUSY;
                  end else if (opb_i == '0) begin
                     hi_d    = opa_i;
                     lo_d    = '1;
                     we_d    = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     div_a_d      = opa_i;
                     div_b_d      = opb_i;
                     div_signed_d = (req_op_i == MD_DIV);
                     state_d      = ST_DIV_BUSY;
                  end
               end
            end
            ST_MUL_BUSY: begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == MUL_LAST) begin
                  {hi_d, lo_d} = res_prod;
                  we_d         = 1'b1;
                  state_d      = ST_DONE;
               end
            end
            ST_DIV_BUSY: begin
               cnt_d = cnt_q + CNT_ONE;
               if (div_ready_i) begin
                  {hi_d, lo_d} = div_result_i;
                  we_d         = 1'b1;
                  state_d      = ST_DONE;
               end else if (cnt_q == DIV_LAST) begin
                  annul   = 1'b1;
                  err_d   = 1'b1;
                  hi_d    = '0;
                  lo_d    = '0;
                  we_d    = 1'b1;
                  state_d = ST_DONE;
               end
            end
            default: begin
               // Write stays pending until EX is released, then is consumed once.
               if (!ex_stall_i) begin
                  we_d    = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         neg_q        <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         div_a_q      <= '0;
         div_b_q      <= '0;
         div_signed_q <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         neg_q        <= neg_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         div_a_q      <= div_a_d;
         div_b_q      <= div_b_d;
         div_signed_q <= div_signed_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         we_q         <= we_d;
         err_q        <= err_d;
      end
   end

   assign mul_a_o      = mul_a_q;
   assign mul_b_o      = mul_b_q;
   assign div_a_o      = div_a_q;
   assign div_b_o      = div_b_q;
   assign div_signed_o = div_signed_q;
   assign div_start_o  = (state_q == ST_DIV_BUSY) && !flush_i;
   assign div_annul_o  = annul;
   assign stall_req_o  = !rst_i && ((state_q == ST_MUL_BUSY) || (state_q == ST_DIV_BUSY) ||
                                    ((state_q == ST_IDLE) && req_valid_i && !flush_i));
   assign hilo_we_o    = we_q;
   assign hi_o         = hi_q;
   assign lo_o         = lo_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider stand-ins.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_LAT     = 3;
   localparam int DIV_TIMEOUT = 40;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic [1:0]  req_op_i = 2'b00;
   logic [31:0] opa_i = '0;
   logic [31:0] opb_i = '0;
   logic        ex_stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] mul_a_o, mul_b_o;
   logic [63:0] mul_prod_i;
   logic        div_start_o, div_signed_o, div_annul_o;
   logic [31:0] div_a_o, div_b_o;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic        stall_req_o, hilo_we_o, err_o;
   logic [31:0] hi_o, lo_o;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   bit          err_exp = 1'b0;
   logic        we_prev = 1'b0;

   always #5 clk_i = ~clk_i;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
      .opa_i(opa_i), .opb_i(opb_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
      .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_prod_i(mul_prod_i),
      .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
      .div_a_o(div_a_o), .div_b_o(div_b_o), .div_ready_i(div_ready_i),
      .div_result_i(div_result_i), .stall_req_o(stall_req_o), .hilo_we_o(hilo_we_o),
      .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
   );

   // Multiplier stand-in: product becomes visible MUL_LAT-1 edges after the operand registers.
   logic [63:0] mul_pipe [MUL_LAT-1];
   always @(posedge clk_i) begin
      mul_pipe[0] <= {32'b0, mul_a_o} * {32'b0, mul_b_o};
      for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
   end
   assign mul_prod_i = mul_pipe[MUL_LAT-2];

   // Divider stand-in: ready in its div_lat-th cycle of a continuous start.
   int div_lat = 33;
   int div_cnt = 0;
   always @(posedge clk_i) begin
      if (div_start_o && !div_annul_o) div_cnt <= div_cnt + 1;
      else div_cnt <= 0;
   end
   assign div_ready_i = div_start_o && (div_cnt == div_lat - 1);
   always_comb begin
      div_result_i = '0;
      if (div_b_o != '0) begin
         if (div_signed_o)
            div_result_i = {32'($signed(div_a_o) % $signed(div_b_o)), 32'($signed(div_a_o) / $signed(div_b_o))};
         else
            div_result_i = {div_a_o % div_b_o, div_a_o / div_b_o};
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural HI/LO result of one instruction.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input int lat);
      longint sa, sb;
      int     qa, qb;
      if (op == 2'b00) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return 64'(sa * sb);
      end
      if (op == 2'b01) return {32'b0, a} * {32'b0, b};
      if (b == '0) return {a, 32'hFFFF_FFFF};
      if (lat >= DIV_TIMEOUT) return 64'h0;
      if (op == 2'b10) begin
         qa = int'(a);
         qb = int'(b);
         return {32'(qa % qb), 32'(qa / qb)};
      end
      return {a % b, a / b};
   endfunction

   // Monitor: compares each new HI/LO write against the oldest expectation.
   always @(negedge clk_i) begin
      if (hilo_we_o && !we_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %h%h expected no write", hi_o, lo_o);
         end else begin
            check("hilo", {hi_o, lo_o}, exp_q.pop_front());
         end
      end
      if (hilo_we_o) check("quiet_in_done", {62'b0, stall_req_o, div_start_o}, 64'h0);
      we_prev <= hilo_we_o;
   end

   // One EX instruction: hold req until flushed or the write is consumed.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input int flush_at);
      int done_n, n, held, st_cnt, ds_cnt, an_cnt, we_cnt;
      bit done, killed, is_div, timeout;
      is_div  = op[1] && (b != '0);
      timeout = is_div && (lat >= DIV_TIMEOUT);
      done_n  = !op[1] ? MUL_LAT + 1 : (b == '0 ? 1 : (timeout ? DIV_TIMEOUT + 1 : lat + 1));
      if (flush_at >= done_n) flush_at = -1;
      killed = (flush_at >= 0);
      if (!killed) exp_q.push_back(ref_result(op, a, b, lat));
      if (!killed && timeout) err_exp = 1'b1;
      div_lat = lat;
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_op_i = op; opa_i = a; opb_i = b;
      held = 0; st_cnt = 0; ds_cnt = 0; an_cnt = 0; we_cnt = 0; done = 1'b0; n = 0;
      while (!done && n < 400) begin
         if (n > 0) begin @(posedge clk_i); #1; end
         flush_i    = (n == flush_at);
         ex_stall_i = hilo_we_o && (held < hold);
         if (ex_stall_i) held++;
         @(negedge clk_i);
         if (stall_req_o) st_cnt++;
         if (div_start_o) ds_cnt++;
         if (div_annul_o) an_cnt++;
         if (hilo_we_o) we_cnt++;
         if (flush_i || (hilo_we_o && !ex_stall_i)) done = 1'b1;
         n++;
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; flush_i = 1'b0; ex_stall_i = 1'b0;
      opa_i = $urandom(); opb_i = $urandom();
      check("txn_bound", {63'b0, done}, 64'h1);
      if (killed) begin
         check("we_after_flush", 64'(we_cnt), 64'h0);
         check("annul_on_flush", 64'(an_cnt), (is_div && flush_at >= 1) ? 64'h1 : 64'h0);
         if (is_div && flush_at >= 1) check("start_before_flush", 64'(ds_cnt), 64'(flush_at - 1));
      end else begin
         check("stall_cycles", 64'(st_cnt), 64'(done_n));
         check("we_cycles", 64'(we_cnt), 64'(hold + 1));
         check("start_cycles", 64'(ds_cnt), is_div ? 64'(timeout ? DIV_TIMEOUT : lat) : 64'h0);
         check("annul_cycles", 64'(an_cnt), timeout ? 64'h1 : 64'h0);
         check("we_cleared", {63'b0, hilo_we_o}, 64'h0);
      end
      check("err", {63'b0, err_o}, {63'b0, err_exp});
      $display("txn op=%0d a=%h b=%h lat=%0d hold=%0d flush_at=%0d stall=%0d start=%0d we=%0d",
               op, a, b, lat, hold, flush_at, st_cnt, ds_cnt, we_cnt);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h0;
         3: return 32'h1;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          fa;
      // Reset state, with a request pending to prove the stall is gated.
      req_valid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_stall", {63'b0, stall_req_o}, 64'h0);
      check("rst_we", {63'b0, hilo_we_o}, 64'h0);
      check("rst_hilo", {hi_o, lo_o}, 64'h0);
      check("rst_err_start", {62'b0, err_o, div_start_o}, 64'h0);
      check("rst_mul_ops", {mul_a_o, mul_b_o}, 64'h0);
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 33, 0, -1);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, -1);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 0, -1);
      issue(2'b11, 32'h0000_1234, 32'd0, 33, 0, -1);
      issue(2'b10, 32'd100, 32'd7, 33, 0, 10);
      issue(2'b01, 32'd2, 32'd3, 33, 0, -1);
      issue(2'b00, 32'd12345, 32'hFFFF_FD4A, 33, 5, -1);
      issue(2'b11, 32'd1000, 32'd3, 20, 0, 20);
      issue(2'b00, 32'd9, 32'd9, 33, 0, MUL_LAT);
      issue(2'b01, 32'd5, 32'd5, 33, 0, 0);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 33, 1, -1);

      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
         issue(op, a, b, int'($urandom_range(1, 39)), int'($urandom_range(0, 3)), fa);
      end

      // Divider never answers: forced abort, sticky error.
      issue(2'b10, 32'd50, 32'd3, 60, 0, -1);
      issue(2'b01, 32'd7, 32'd6, 33, 0, -1);

      // Asynchronous reset in the middle of a divide.
      div_lat = 33;
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_op_i = 2'b10; opa_i = 32'd99; opb_i = 32'd4;
      repeat (12) @(posedge clk_i);
      #1;
      check("busy_before_reset", {62'b0, div_start_o, stall_req_o}, 64'h3);
      #2 rst_i = 1'b1;
      #1;
      check("arst_ctrl", {59'b0, stall_req_o, div_start_o, div_annul_o, hilo_we_o, err_o}, 64'h0);
      check("arst_hilo", {hi_o, lo_o}, 64'h0);
      check("arst_div_ops", {div_a_o, div_b_o}, 64'h0);
      check("arst_div_signed", {63'b0, div_signed_o}, 64'h0);
      req_valid_i = 1'b0;
      err_exp = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      issue(2'b00, 32'hFFFF_FFFF, 32'd1, 33, 0, -1);

      repeat (3) @(posedge clk_i);
      check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
